// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single fixed-latency memory port.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int DATA_W        = 32,
    parameter int LAT           = 2,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [DATA_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_s;
    logic              arb_if_s;
    logic              arb_dm_s;
    logic              grant_if_s;
    logic              grant_dm_s;
    logic              last_busy_s;

    logic              if_gnt_r;
    logic              dm_gnt_r;
    logic              if_valid_r;
    logic              dm_valid_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [DATA_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STREAK_W = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);

    logic [STREAK_W-1:0] streak_r;
    logic [STREAK_W-1:0] streak_s;
    logic                force_if_s;

    // Arbitration with the fetch starvation guard and streak bookkeeping
    always_comb begin
        force_if_s = 1'b0;
        arb_if_s   = 1'b0;
        arb_dm_s   = 1'b0;
        streak_s   = streak_r;
        force_if_s = dm_req && if_req && (streak_r == STREAK_W'(MAX_DM_STREAK));
        arb_dm_s   = dm_req && !force_if_s;
        arb_if_s   = if_req && (force_if_s || !dm_req);
        if (state_r == IDLE) begin
            // Only dm wins made while fetch is waiting extend the streak
            if (arb_dm_s && if_req) begin
                streak_s = streak_r + STREAK_W'(1);
            end else begin
                streak_s = {STREAK_W{1'b0}};
            end
        end else begin
            streak_s = streak_r;
        end
    end

    // Streak counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_r <= {STREAK_W{1'b0}};
        end else begin
            streak_r <= streak_s;
        end
    end
`else
    // Strict data-port priority
    always_comb begin
        arb_dm_s = dm_req;
        arb_if_s = if_req && !dm_req;
    end
`endif

    // Next-state, busy counter and grant decode
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        grant_if_s  = 1'b0;
        grant_dm_s  = 1'b0;
        last_busy_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (arb_dm_s) begin
                    state_s    = BUSY_DM;
                    cnt_s      = LAT_M1;
                    grant_dm_s = 1'b1;
                end else if (arb_if_s) begin
                    state_s    = BUSY_IF;
                    cnt_s      = LAT_M1;
                    grant_if_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_IF, BUSY_DM: begin
                // Counter stops at zero; that cycle is the last one with mem_en
                if (cnt_r == 4'd0) begin
                    state_s     = RESP;
                    last_busy_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State and busy counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Memory port command registers, loaded at grant and held through BUSY
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {DATA_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_en_r <= (state_s == BUSY_IF) || (state_s == BUSY_DM);
            if (grant_if_s) begin
                mem_we_r    <= 1'b0;
                mem_addr_r  <= if_addr;
                mem_wdata_r <= {DATA_W{1'b0}};
            end else if (grant_dm_s) begin
                mem_we_r    <= dm_we;
                mem_addr_r  <= dm_addr;
                mem_wdata_r <= dm_wdata;
            end else if (last_busy_s) begin
                mem_we_r <= 1'b0;
            end
        end
    end

    // Grant and response pulses plus held read data per port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_gnt_r   <= 1'b0;
            dm_gnt_r   <= 1'b0;
            if_valid_r <= 1'b0;
            dm_valid_r <= 1'b0;
            if_rdata_r <= {DATA_W{1'b0}};
            dm_rdata_r <= {DATA_W{1'b0}};
        end else begin
            if_gnt_r   <= grant_if_s;
            dm_gnt_r   <= grant_dm_s;
            if_valid_r <= last_busy_s && (state_r == BUSY_IF);
            dm_valid_r <= last_busy_s && (state_r == BUSY_DM);
            if (last_busy_s && (state_r == BUSY_IF)) begin
                if_rdata_r <= mem_rdata;
            end
            if (last_busy_s && (state_r == BUSY_DM)) begin
                dm_rdata_r <= mem_we_r ? {DATA_W{1'b0}} : mem_rdata;
            end
        end
    end

    assign if_gnt    = if_gnt_r;
    assign dm_gnt    = dm_gnt_r;
    assign if_valid  = if_valid_r;
    assign dm_valid  = dm_valid_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    // Follows if_req within the cycle; forced low while reset is held
    assign stall_if  = reset & if_req & ~if_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic against a transaction-timing reference model.
module tb_mem_port_arbiter;

    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, dm_req, dm_we;
    logic [DW-1:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic          if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we, stall_if;
    logic [DW-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    int n_cmp = 0;
    int n_err = 0;

    // model state: one outstanding access described by its arbitration cycle
    int            cyc = 0;
    int            next_arb = 0;
    bit            have = 1'b0;
    int            t_acc = 0;
    bit            a_dm, a_we;
    logic [DW-1:0] a_addr, a_wdata, cap;
    logic [DW-1:0] e_if_rdata = 32'h0;
    logic [DW-1:0] e_dm_rdata = 32'h0;
    int            streak = 0;

    mem_port_arbiter #(.DATA_W(DW), .LAT(LAT), .MAX_DM_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_gnt"},   {31'd0, if_gnt},   32'h0);
        check({tag, "_dm_gnt"},   {31'd0, dm_gnt},   32'h0);
        check({tag, "_if_valid"}, {31'd0, if_valid}, 32'h0);
        check({tag, "_dm_valid"}, {31'd0, dm_valid}, 32'h0);
        check({tag, "_mem_en"},   {31'd0, mem_en},   32'h0);
        check({tag, "_mem_we"},   {31'd0, mem_we},   32'h0);
        check({tag, "_stall_if"}, {31'd0, stall_if}, 32'h0);
        check({tag, "_if_rdata"}, if_rdata,  32'h0);
        check({tag, "_dm_rdata"}, dm_rdata,  32'h0);
        check({tag, "_mem_addr"}, mem_addr,  32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // One cycle: check outputs of this cycle, drive inputs, advance the model.
    task automatic body(input bit ir, input logic [DW-1:0] ia, input bit dr, input bit dw,
                        input logic [DW-1:0] da, input logic [DW-1:0] dwd, input logic [DW-1:0] mr);
        bit e_en, e_vld, e_ifv, want_if, want_dm;
        e_en  = have && (cyc >= t_acc + 1) && (cyc <= t_acc + LAT);
        e_vld = have && (cyc == t_acc + LAT + 1);
        e_ifv = e_vld && !a_dm;
        if (e_vld) begin
            if (a_dm) e_dm_rdata = a_we ? 32'h0 : cap;
            else      e_if_rdata = cap;
        end
        check("if_gnt",   {31'd0, if_gnt},   {31'd0, have && !a_dm && (cyc == t_acc + 1)});
        check("dm_gnt",   {31'd0, dm_gnt},   {31'd0, have &&  a_dm && (cyc == t_acc + 1)});
        check("if_valid", {31'd0, if_valid}, {31'd0, e_ifv});
        check("dm_valid", {31'd0, dm_valid}, {31'd0, e_vld && a_dm});
        check("mem_en",   {31'd0, mem_en},   {31'd0, e_en});
        check("if_rdata", if_rdata, e_if_rdata);
        check("dm_rdata", dm_rdata, e_dm_rdata);
        if (e_en) begin
            check("mem_we",    {31'd0, mem_we}, {31'd0, a_we});
            check("mem_addr",  mem_addr,  a_addr);
            check("mem_wdata", mem_wdata, a_wdata);
        end
        if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw;
        dm_addr = da; dm_wdata = dwd; mem_rdata = mr;
        #1;
        check("stall_if", {31'd0, stall_if}, {31'd0, ir && !e_ifv});
        if (e_en && (cyc == t_acc + LAT)) cap = mr;
        if (cyc >= next_arb) begin
            want_if = 1'b0;
            want_dm = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            if (dr && ir && streak == MAXS) want_if = 1'b1;
            else if (dr) want_dm = 1'b1;
            else if (ir) want_if = 1'b1;
            streak = (want_dm && ir) ? streak + 1 : 0;
`else
            if (dr) want_dm = 1'b1;
            else if (ir) want_if = 1'b1;
`endif
            if (want_dm || want_if) begin
                have = 1'b1; t_acc = cyc; a_dm = want_dm;
                a_we    = want_dm ? dw : 1'b0;
                a_addr  = want_dm ? da : ia;
                a_wdata = want_dm ? dwd : 32'h0;
                next_arb = cyc + LAT + 2;
            end else begin
                next_arb = cyc + 1;
            end
        end
        cyc++;
    endtask

    task automatic step(input bit ir, input logic [DW-1:0] ia, input bit dr, input bit dw,
                        input logic [DW-1:0] da, input logic [DW-1:0] dwd, input logic [DW-1:0] mr);
        @(negedge clk);
        body(ir, ia, dr, dw, da, dwd, mr);
    endtask

    task automatic idle(input int n, input logic [DW-1:0] mr);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, mr);
    endtask

    task automatic assert_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        if_req = 1'b1;
        #1;
        check_all_zero(tag);
        have = 1'b0; e_if_rdata = 32'h0; e_dm_rdata = 32'h0; streak = 0;
    endtask

    task automatic release_reset(input bit ir, input logic [DW-1:0] ia, input bit dr, input bit dw,
                                 input logic [DW-1:0] da, input logic [DW-1:0] dwd, input logic [DW-1:0] mr);
        @(negedge clk);
        reset = 1'b1;
        have = 1'b0;
        next_arb = cyc;
        body(ir, ia, dr, dw, da, dwd, mr);
    endtask

    int gnt_if_count;
    int exp_if_count;

    initial begin
        reset = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = 32'h0; dm_wdata = 32'h0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("rst");

        // read: request present on the very first edge after release
        release_reset(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF);
        idle(4, 32'hDEADBEEF);
        check("read_rdata", if_rdata, 32'hDEADBEEF);

        // write
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h1234, 32'h5555AAAA);
        idle(4, 32'h5555AAAA);
        check("write_rdata", dm_rdata, 32'h0);

        // simultaneous fetch and data read
        for (int i = 0; i < 8; i++) step(1'b1, 32'h20, 1'b1, 1'b0, 32'h44, 32'h0, 32'h0BAD0000 + 32'(i));
        idle(4, 32'h0);

        // continuous contention: streak guard behaviour
        idle(6, 32'h0);
        gnt_if_count = 0;
        for (int i = 0; i < 80; i++) begin
            step(1'b1, 32'h100 + 32'(i), 1'b1, i[0], 32'h200 + 32'(i), 32'h300 + 32'(i), 32'hA0000000 + 32'(i));
            if (if_gnt) gnt_if_count++;
        end
`ifdef ARB_STARVE_GUARD_EN
        exp_if_count = 4;
`else
        exp_if_count = 0;
`endif
        check("streak_if_gnts", 32'(gnt_if_count), 32'(exp_if_count));
        idle(6, 32'h0);

        // reset during the second BUSY_DM cycle
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 32'h77777777);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h77777777);
        assert_reset("midrst");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_all_zero("inrst");
        end
        release_reset(1'b0, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0, 32'hCAFE0001);
        idle(4, 32'hCAFE0001);
        check("post_rst_rdata", dm_rdata, 32'hCAFE0001);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 9) < 4,
                 $urandom_range(0, 1) == 1, $urandom(), $urandom(), $urandom());
        end
        idle(6, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
